fp_div_arbiter: RTL

Round-robin arbiter and sequencer that shares one `fp_div` instance among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and pulses the divider's `start`. It waits for `done` under a watchdog, then returns the result, flags and requester ID over a single valid/ready response channel. It sits between the calculator's operation dispatch logic and the divider datapath.

---
 rtl/fp_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/fp_div_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the calculator datapath arbiters.
package fp_pkg;

   localparam logic [63:0] FP_QNAN = 64'h7FF8000000000001;

   // Bit positions inside the 3-bit {overflow, underflow, invalid} flag field
   localparam int FLG_OV  = 2;
   localparam int FLG_UN  = 1;
   localparam int FLG_INV = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } div_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         grant_any
);

   function automatic logic [W-1:0] rot(input logic [W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return W'(s);
   endfunction

   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!grant_any && req[rot(ptr, k)]) begin
            grant_any = 1'b1;
            grant_idx = rot(ptr, k);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_onehot
         assign grant[gi] = grant_any && (grant_idx == W'(gi));
      end
   endgenerate

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one fp_div among N_REQ requesters: round-robin accept, single issue,
// watchdog-guarded wait, and a held response until the consumer accepts it.
module fp_div_arbiter
   import fp_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int TIMEOUT = 255,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [64*N_REQ-1:0] req_a,
   input  logic [64*N_REQ-1:0] req_b,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [ID_W-1:0]     resp_id,
   output logic [63:0]         resp_data,
   output logic [2:0]          resp_flags,
   output logic                resp_timeout,
   output logic                busy,
   output logic                div_start,
   output logic [63:0]         div_a,
   output logic [63:0]         div_b,
   output logic                div_rst_n,
   input  logic [63:0]         div_out,
   input  logic                div_done,
   input  logic                div_overflow,
   input  logic                div_underflow,
   input  logic                div_invalid
);

   div_arb_state_t  state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [63:0]     a_q, a_d, b_q, b_d;
   logic [63:0]     data_q, data_d;
   logic [2:0]      flags_q, flags_d;
   logic            tmo_q, tmo_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            drst_n_q, drst_n_d;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_any;
   logic [63:0]      a_arr [N_REQ];
   logic [63:0]      b_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[64*gi +: 64];
         assign b_arr[gi] = req_b[64*gi +: 64];
      end
   endgenerate

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      a_d      = a_q;
      b_d      = b_q;
      data_d   = data_q;
      flags_d  = flags_q;
      tmo_d    = tmo_q;
      cnt_d    = cnt_q;
      drst_n_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               a_d      = a_arr[grant_idx];
               b_d      = b_arr[grant_idx];
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done arriving on the very cycle the watchdog expires still wins
            if (div_done) begin
               data_d           = div_out;
               flags_d[FLG_OV]  = div_overflow;
               flags_d[FLG_UN]  = div_underflow;
               flags_d[FLG_INV] = div_invalid;
               tmo_d            = 1'b0;
               state_d          = RESP;
            end else if (cnt_q == 16'(TIMEOUT)) begin
               data_d           = FP_QNAN;
               flags_d          = '0;
               flags_d[FLG_INV] = 1'b1;
               tmo_d            = 1'b1;
               drst_n_d         = 1'b0;
               state_d          = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         data_q   <= '0;
         flags_q  <= '0;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
         drst_n_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         data_q   <= data_d;
         flags_q  <= flags_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
         drst_n_q <= drst_n_d;
      end
   end

   // Gated by rst so no requester sees an accept while reset is held
   assign req_ready    = (state_q == IDLE && !rst) ? grant : '0;
   assign busy         = (state_q != IDLE);
   assign div_start    = (state_q == ISSUE);
   assign resp_valid   = (state_q == RESP);
   assign resp_id      = id_q;
   assign resp_data    = data_q;
   assign resp_flags   = flags_q;
   assign resp_timeout = tmo_q;
   assign div_a        = a_q;
   assign div_b        = b_q;
   assign div_rst_n    = drst_n_q;

endmodule
